operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Upstream input stage of the IEEE-754 single-precision multiplier.
- Debounces the active-low enter push-button and captures 8-bit switch bytes.
- Assembles the bytes into two 32-bit operands, A then B, MSB byte first.
- Presents both operands to the multiplier control/datapath with a valid/ack handshake, and exposes progress for display.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles of the synchronized button level needed to accept a level change. Minimum 1.
- CNT_W, 16: width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nreset  input  1  asynchronous, active-low reset.
- nenter  input  1  raw active-low enter button; asynchronous to clk.
- inputdata  input  8  switch byte; sampled only on an accepted press.
- op_a  output  32  assembled operand A.
- op_b  output  32  assembled operand B.
- operands_valid  output  1  high while op_a/op_b are complete and held.
- operands_ack  input  1  downstream consumed the operands; sampled only while operands_valid=1.
- byte_index  output  3  number of bytes captured so far in the current pair, 0..7.
- press_pulse  output  1  one-cycle strobe per accepted press; for display/debug.

Behaviour:
- Reset (nreset=0, asynchronous, any time including mid-collection):
  - op_a=0, op_b=0, operands_valid=0, byte_index=0, press_pulse=0.
  - State=COLLECT_A; debounced level=1 (released); debounce counter=0; synchronizer flops=1.
- Synchronizer: nenter passes through 2 flops to give enter_s.
- Debouncer:
  - When enter_s differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes enter_s and the counter clears.
  - A 1->0 transition of the debounced level raises press_pulse for exactly 1 cycle, in the cycle after the transition.
  - Release (0->1) produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Holding the button gives one pulse only.
- Latency: from nenter falling to press_pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states COLLECT_A, COLLECT_B, HOLD:
  - COLLECT_A, on press_pulse:
    - op_a <= {op_a[23:0], inputdata}; byte_index increments.
    - When byte_index was 3, go to COLLECT_B.
  - COLLECT_B, on press_pulse:
    - op_b <= {op_b[23:0], inputdata}; byte_index increments.
    - When byte_index was 7, go to HOLD and set operands_valid=1 on the next cycle.
  - HOLD:
    - op_a/op_b are frozen; press_pulse is still generated but ignored (no shift, byte_index stays 7).
    - On operands_ack=1: operands_valid <= 0, byte_index <= 0, go to COLLECT_A.
    - op_a/op_b keep their values until overwritten by new shifts.
- operands_ack is ignored outside HOLD.
- operands_valid is high for at least 1 cycle, even if ack is already high when HOLD is entered.
- A press_pulse and an ack in the same HOLD cycle: the ack is honoured and the press is discarded. The next press starts the new op_a.
- Registers are 32-bit; no arithmetic beyond the byte_index increment. byte_index never exceeds 7.
- inputdata is assumed stable around the press; it is sampled only in the press_pulse cycle.

Optional Feature:
- Macro: OPERAND_CLASS_EN.
- When defined, two extra outputs are added: class_a[2:0] and class_b[2:0].
  - Each is registered and updated with operands_valid.
  - Encoding: 000 normal, 001 zero (exp=0, frac=0), 010 subnormal (exp=0, frac!=0), 011 infinity (exp=FF, frac=0), 100 NaN (exp=FF, frac!=0).
  - Reset value 000.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Press sequence with bytes 40,40,00,00,40,00,00,00 -> operands_valid=1, op_a=32'h40400000, op_b=32'h40000000, byte_index=7; ack -> valid=0 next cycle, byte_index=0.
- nenter low pulse of 3 cycles, then a 30-cycle hold -> no pulse for the glitch; exactly one press_pulse for the hold, arriving 7 cycles after the falling edge.
- Extra presses with byte FF while in HOLD -> op_a/op_b unchanged, valid stays 1.
- ack already high when HOLD is entered -> valid high exactly 1 cycle, then COLLECT_A.
- nreset asserted after 5 bytes -> all outputs 0 immediately (asynchronously); the next 8 bytes form a fresh pair.
- With OPERAND_CLASS_EN: op_a=00000000, op_b=7F800001 -> class_a=001, class_b=100.

Source files
------------

// File: rtl/operand_loader.sv
// Input stage of the FP32 multiplier: debounces the enter button and packs switch bytes into operands A then B.
// Optional OPERAND_CLASS_EN macro adds registered class_a/class_b outputs.
module operand_loader #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        nenter,
  input  logic [7:0]  inputdata,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        operands_valid,
  input  logic        operands_ack,
  output logic [2:0]  byte_index,
  output logic        press_pulse
`ifdef OPERAND_CLASS_EN
  ,
  output logic [2:0]  class_a,
  output logic [2:0]  class_b
`endif
);

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    HOLD      = 2'd2
  } state_t;

  // Last count value before the level is accepted: D differing cycles in total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  state_t           state;
  logic             sync1;
  logic             enter_s;
  logic             deb;
  logic             deb_prev;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_b_next;

  assign op_b_next = {op_b[23:0], inputdata};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1       <= 1'b1;
      enter_s     <= 1'b1;
      deb         <= 1'b1;
      deb_prev    <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= nenter;
      enter_s     <= sync1;
      deb_prev    <= deb;
      press_pulse <= deb_prev & ~deb;
      if (enter_s != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= enter_s;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef OPERAND_CLASS_EN
  function automatic logic [2:0] classify(input logic [30:0] v);
    logic [2:0] c;
    if (v[30:23] == 8'h00)      c = (v[22:0] == 23'd0) ? 3'b001 : 3'b010;
    else if (v[30:23] == 8'hFF) c = (v[22:0] == 23'd0) ? 3'b011 : 3'b100;
    else                        c = 3'b000;
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= COLLECT_A;
      op_a           <= '0;
      op_b           <= '0;
      operands_valid <= 1'b0;
      byte_index     <= '0;
`ifdef OPERAND_CLASS_EN
      class_a        <= '0;
      class_b        <= '0;
`endif
    end else begin
      case (state)
        COLLECT_A: begin
          if (press_pulse) begin
            op_a       <= {op_a[23:0], inputdata};
            byte_index <= byte_index + 3'd1;
            if (byte_index == 3'd3) state <= COLLECT_B;
          end
        end
        COLLECT_B: begin
          if (press_pulse) begin
            op_b <= op_b_next;
            // The eighth byte leaves byte_index saturated at 7 for the whole hold.
            if (byte_index == 3'd7) begin
              state          <= HOLD;
              operands_valid <= 1'b1;
`ifdef OPERAND_CLASS_EN
              class_a        <= classify(op_a[30:0]);
              class_b        <= classify(op_b_next[30:0]);
`endif
            end else begin
              byte_index <= byte_index + 3'd1;
            end
          end
        end
        HOLD: begin
          if (operands_ack) begin
            operands_valid <= 1'b0;
            byte_index     <= '0;
            state          <= COLLECT_A;
          end
        end
        default: state <= COLLECT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4; completed pairs are checked by a scoreboard monitor.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        nreset;
  logic        nenter;
  logic [7:0]  inputdata;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        operands_valid;
  logic        operands_ack;
  logic [2:0]  byte_index;
  logic        press_pulse;
`ifdef OPERAND_CLASS_EN
  logic [2:0]  class_a;
  logic [2:0]  class_b;
`endif

  operand_loader #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) dut (
    .clk(clk),
    .nreset(nreset),
    .nenter(nenter),
    .inputdata(inputdata),
    .op_a(op_a),
    .op_b(op_b),
    .operands_valid(operands_valid),
    .operands_ack(operands_ack),
    .byte_index(byte_index),
    .press_pulse(press_pulse)
`ifdef OPERAND_CLASS_EN
    ,
    .class_a(class_a),
    .class_b(class_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  pair_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    pulse_cnt = 0;
  int    vlen = 0;
  int    last_len = 0;
  logic  vprev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected pair on every rising edge of operands_valid.
  always @(negedge clk) begin
    if (!nreset) begin
      vprev = 1'b0;
      vlen  = 0;
    end else begin
      if (press_pulse) pulse_cnt++;
      if (operands_valid) begin
        vlen++;
        if (!vprev) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'd1, 32'd0);
          end else begin
            pair_t e;
            e = exp_q.pop_front();
            chk("sb_op_a", op_a, e.a);
            chk("sb_op_b", op_b, e.b);
            chk("sb_byte_index", {29'd0, byte_index}, 32'd7);
          end
        end
      end else if (vprev) begin
        last_len = vlen;
        vlen     = 0;
      end
      vprev = operands_valid;
    end
  end

  task automatic press(input logic [7:0] b);
    @(posedge clk); #1;
    inputdata = b;
    nenter    = 1'b0;
    repeat (12) @(posedge clk);
    #1 nenter = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic press_pair(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    exp_q.push_back(p);
    for (int i = 3; i >= 0; i--) press(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) press(b[i*8 +: 8]);
  endtask

  task automatic ack_once();
    @(posedge clk); #1 operands_ack = 1'b1;
    @(posedge clk); #1 operands_ack = 1'b0;
  endtask

  initial begin
    int    lat;
    int    pc0;
    pair_t p;

    nreset       = 1'b0;
    nenter       = 1'b1;
    inputdata    = 8'h00;
    operands_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_valid", {31'd0, operands_valid}, 32'd0);
    chk("rst_byte_index", {29'd0, byte_index}, 32'd0);
    chk("rst_press_pulse", {31'd0, press_pulse}, 32'd0);
    @(posedge clk); #1 nreset = 1'b1;
    repeat (3) @(posedge clk);

    // 3-cycle glitch: one short of the debounce window, must not pulse.
    pc0 = pulse_cnt;
    #1 nenter = 1'b0;
    repeat (3) @(posedge clk);
    #1 nenter = 1'b1;
    repeat (12) @(posedge clk);
    chk("glitch_no_pulse", pulse_cnt, pc0);

    // 30-cycle hold: single pulse at 7 cycles; it also captures byte 1 of pair 1.
    p.a = 32'h40400000;
    p.b = 32'h40000000;
    exp_q.push_back(p);
    pc0 = pulse_cnt;
    lat = 0;
    #1;
    nenter    = 1'b0;
    inputdata = 8'h40;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (press_pulse && lat == 0) lat = i;
    end
    repeat (10) @(posedge clk);
    #1 nenter = 1'b1;
    repeat (12) @(posedge clk);
    chk("press_latency", lat, 32'd7);
    chk("hold_one_pulse", pulse_cnt - pc0, 32'd1);
    chk("idx_after_first", {29'd0, byte_index}, 32'd1);
    press(8'h40); press(8'h00); press(8'h00);
    press(8'h40); press(8'h00); press(8'h00); press(8'h00);
    chk("valid_after_pair1", {31'd0, operands_valid}, 32'd1);
    chk("idx_hold", {29'd0, byte_index}, 32'd7);

    press(8'hFF); press(8'hFF);
    chk("hold_frozen_a", op_a, 32'h40400000);
    chk("hold_frozen_b", op_b, 32'h40000000);
    chk("hold_valid", {31'd0, operands_valid}, 32'd1);
    chk("hold_idx", {29'd0, byte_index}, 32'd7);

    ack_once();
    chk("ack_valid", {31'd0, operands_valid}, 32'd0);
    chk("ack_idx", {29'd0, byte_index}, 32'd0);
    chk("ack_keep_a", op_a, 32'h40400000);

    // Ack held high throughout: ignored while collecting, valid lasts one cycle.
    @(posedge clk); #1 operands_ack = 1'b1;
    p.a = 32'h11223344;
    p.b = 32'h55667788;
    exp_q.push_back(p);
    press(8'h11); press(8'h22); press(8'h33); press(8'h44);
    chk("ackhigh_idx_mid", {29'd0, byte_index}, 32'd4);
    chk("ackhigh_a_mid", op_a, 32'h11223344);
    press(8'h55); press(8'h66); press(8'h77); press(8'h88);
    chk("ackhigh_valid_len", last_len, 32'd1);
    chk("ackhigh_valid_low", {31'd0, operands_valid}, 32'd0);
    chk("ackhigh_idx_back", {29'd0, byte_index}, 32'd0);
    chk("ackhigh_keep_b", op_b, 32'h55667788);
    #1 operands_ack = 1'b0;

    // Asynchronous reset in the middle of collection.
    press(8'hAA); press(8'hBB); press(8'hCC); press(8'hDD); press(8'hEE);
    #3 nreset = 1'b0;
    #1;
    chk("mid_rst_op_a", op_a, 32'd0);
    chk("mid_rst_op_b", op_b, 32'd0);
    chk("mid_rst_idx", {29'd0, byte_index}, 32'd0);
    chk("mid_rst_valid", {31'd0, operands_valid}, 32'd0);
    chk("mid_rst_pulse", {31'd0, press_pulse}, 32'd0);
    @(posedge clk); #1 nreset = 1'b1;
    repeat (2) @(posedge clk);
    press_pair(32'h3F800000, 32'hC0490FDB);
    chk("pair3_valid", {31'd0, operands_valid}, 32'd1);
    ack_once();

`ifdef OPERAND_CLASS_EN
    press_pair(32'h00000000, 32'h7F800001);
    chk("class_a_zero", {29'd0, class_a}, 32'd1);
    chk("class_b_nan", {29'd0, class_b}, 32'd4);
    ack_once();
`endif

    repeat (4) @(posedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
